// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit -- multi-cycle multiply/divide unit with architectural HI/LO (EX stage)
//
// Takes the same forwarded operand pair as the ALU (src_a = rs, src_b = rt).
// mthi/mtlo write HI/LO on the accept edge. mult/multu/div/divu compute their
// 64-bit result on the accept edge into a pending register. The pending value
// is committed to HI/LO after MUL_CYCLES/DIV_CYCLES busy cycles. While an
// operation is in flight, stall_req holds the pipeline.
//
// Optional feature: define MD_MADD_EN to enable madd/maddu/msub/msubu
// (md_op 7..10). These accumulate into {HI,LO} with MUL_CYCLES latency. When
// the macro is undefined, those opcodes are no-ops.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   md_op valid this cycle
//   md_op      in   4   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,
//                       7 madd,8 maddu,9 msub,10 msubu
//   src_a      in   32  operand 1 (rs)
//   src_b      in   32  operand 2 (rt)
//   flush      in   1   abort in-flight op, drop a same-cycle start
//   busy       out  1   high while the cycle counter is non-zero
//   stall_req  out  1   busy, or a multi-cycle op being presented
//   done       out  1   one-cycle pulse when HI/LO commit
//   hi         out  32  HI register
//   lo         out  32  LO register
// -----------------------------------------------------------------------------
module md_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

`ifdef MD_MADD_EN
    localparam logic MADD_EN = 1'b1;
`else
    localparam logic MADD_EN = 1'b0;
`endif

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      phi_q, phi_d;
    logic [31:0]      plo_q, plo_d;

    // ---------------- opcode decode ----------------
    logic is_mul, is_div, is_mac, is_long;

    assign is_mul  = (md_op == OP_MULT) || (md_op == OP_MULTU);
    assign is_div  = (md_op == OP_DIV)  || (md_op == OP_DIVU);
    assign is_mac  = MADD_EN && (md_op >= OP_MADD) && (md_op <= OP_MSUBU);
    assign is_long = is_mul || is_div || is_mac;

    // ---------------- arithmetic ----------------
    logic [63:0] prod_s, prod_u, acc, result;
    logic        div_zero, div_ovf;
    logic [31:0] div_b;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;

    assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    assign prod_u = {32'd0, src_a} * {32'd0, src_b};
    assign acc    = {hi_q, lo_q};

    assign div_zero = (src_b == 32'd0);
    assign div_ovf  = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
    // The special cases are muxed in below. Substituting divisor 1 keeps the
    // divider itself free of undefined operand pairs.
    assign div_b    = (div_zero || div_ovf) ? 32'd1 : src_b;

    assign quo_s = $signed(src_a) / $signed(div_b);
    assign rem_s = $signed(src_a) % $signed(div_b);
    assign quo_u = src_a / div_b;
    assign rem_u = src_a % div_b;

    always_comb begin
        result = 64'd0;
        case (md_op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV: begin
                if (div_zero)     result = {src_a, 32'hFFFF_FFFF};
                else if (div_ovf) result = {32'd0, 32'h8000_0000};
                else              result = {rem_s, quo_s};
            end
            OP_DIVU: begin
                if (div_zero) result = {src_a, 32'hFFFF_FFFF};
                else          result = {rem_u, quo_u};
            end
            OP_MADD:  result = acc + prod_s;
            OP_MADDU: result = acc + prod_u;
            OP_MSUB:  result = acc - prod_s;
            OP_MSUBU: result = acc - prod_u;
            default:  result = 64'd0;
        endcase
    end

    // ---------------- next-state ----------------
    // Flush wins over everything, including a start or a commit on the same edge.
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        hi_d   = hi_q;
        lo_d   = lo_q;
        phi_d  = phi_q;
        plo_d  = plo_q;
        if (flush) begin
            cnt_d  = '0;
            busy_d = 1'b0;
            phi_d  = 32'd0;
            plo_d  = 32'd0;
        end else if (busy_q) begin
            // A start seen while busy is ignored; the hazard unit holds EX.
            cnt_d  = cnt_q - CNT_ONE;
            busy_d = (cnt_q != CNT_ONE);
            if (cnt_q == CNT_ONE) begin
                hi_d   = phi_q;
                lo_d   = plo_q;
                done_d = 1'b1;
            end
        end else if (start) begin
            if (md_op == OP_MTHI) begin
                hi_d = src_a;
            end else if (md_op == OP_MTLO) begin
                lo_d = src_a;
            end else if (is_long) begin
                phi_d  = result[63:32];
                plo_d  = result[31:0];
                cnt_d  = is_div ? DIV_CNT : MUL_CNT;
                busy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            phi_q  <= 32'd0;
            plo_q  <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            phi_q  <= phi_d;
            plo_q  <= plo_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign stall_req = busy_q | (start & is_long);

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    md_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .busy(busy), .stall_req(stall_req), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op for one accept edge, then observe 15 cycles.
    task automatic run_long(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int bc, output int dn, output int hold_bad, output logic st0);
        logic [31:0] old_hi, old_lo;
        old_hi = hi; old_lo = lo;
        md_op = op; src_a = a; src_b = b; start = 1'b1;
        #1 st0 = stall_req;
        step();
        start = 1'b0; md_op = 4'd0;
        bc = 0; dn = 0; hold_bad = 0;
        for (int k = 0; k < 15; k++) begin
            if (busy) begin
                bc++;
                if (hi !== old_hi || lo !== old_lo) hold_bad++;
            end
            if (done) dn++;
            step();
        end
    endtask

    task automatic test_reset();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
    endtask

    task automatic test_mthi_mtlo();
        start = 1'b1; md_op = 4'd5; src_a = 32'h1234; src_b = 32'd0;
        #1;
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL mthi_stall got=%b exp=0", stall_req); end
        step();
        checks++; if (hi !== 32'h1234) begin failures++; $display("FAIL mthi_hi got=%h exp=00001234", hi); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mthi_busy got=%b%b exp=00", busy, done); end
        md_op = 4'd6; src_a = 32'h5678;
        step();
        start = 1'b0; md_op = 4'd0;
        checks++; if (lo !== 32'h5678) begin failures++; $display("FAIL mtlo_lo got=%h exp=00005678", lo); end
        checks++; if (hi !== 32'h1234) begin failures++; $display("FAIL mtlo_hi got=%h exp=00001234", hi); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mtlo_busy got=%b%b exp=00", busy, done); end
    endtask

    task automatic test_mult();
        int bc, dn, hb; logic st0;
        run_long(4'd1, 32'hFFFF_FFFE, 32'd3, bc, dn, hb, st0);
        checks++; if (st0 !== 1'b1) begin failures++; $display("FAIL mult_stall got=%b exp=1", st0); end
        checks++; if (bc != 5) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=5", bc); end
        checks++; if (dn != 1) begin failures++; $display("FAIL mult_done_pulses got=%0d exp=1", dn); end
        checks++; if (hb != 0) begin failures++; $display("FAIL mult_hold got=%0d exp=0", hb); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFFA) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
    endtask

    task automatic test_multu();
        int bc, dn, hb; logic st0;
        run_long(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dn, hb, st0);
        checks++; if (bc != 5 || dn != 1) begin failures++; $display("FAIL multu_timing got=%0d/%0d exp=5/1", bc, dn); end
        checks++; if (hb != 0) begin failures++; $display("FAIL multu_hold got=%0d exp=0", hb); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
    endtask

    task automatic test_div();
        int bc, dn, hb; logic st0;
        run_long(4'd3, 32'hFFFF_FFF9, 32'd2, bc, dn, hb, st0);
        checks++; if (st0 !== 1'b1) begin failures++; $display("FAIL div_stall got=%b exp=1", st0); end
        checks++; if (bc != 10 || dn != 1) begin failures++; $display("FAIL div_timing got=%0d/%0d exp=10/1", bc, dn); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
        run_long(4'd3, 32'd7, 32'hFFFF_FFFE, bc, dn, hb, st0);
        checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin failures++; $display("FAIL div_negb got=%h_%h exp=00000001_fffffffd", hi, lo); end
        run_long(4'd4, 32'd7, 32'd0, bc, dn, hb, st0);
        checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'd7) begin failures++; $display("FAIL divu_zero got=%h_%h exp=00000007_ffffffff", hi, lo); end
        run_long(4'd4, 32'hFFFF_FFF9, 32'd2, bc, dn, hb, st0);
        checks++; if (lo !== 32'h7FFF_FFFC || hi !== 32'd1) begin failures++; $display("FAIL divu_big got=%h_%h exp=00000001_7ffffffc", hi, lo); end
        run_long(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, bc, dn, hb, st0);
        checks++; if (lo !== 32'h8000_0000 || hi !== 32'd0) begin failures++; $display("FAIL div_ovf got=%h_%h exp=00000000_80000000", hi, lo); end
        run_long(4'd3, 32'hFFFF_FFF9, 32'd0, bc, dn, hb, st0);
        checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFF9) begin failures++; $display("FAIL div_zero got=%h_%h exp=fffffff9_ffffffff", hi, lo); end
    endtask

    task automatic test_flush();
        logic [31:0] old_hi, old_lo; int dn, bc;
        old_hi = hi; old_lo = lo;
        start = 1'b1; md_op = 4'd3; src_a = 32'd100; src_b = 32'd7;
        step();
        start = 1'b0; md_op = 4'd0;
        step(); step(); step();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_busy_before got=%b exp=1", busy); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy_after got=%b exp=0", busy); end
        dn = 0; bc = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) dn++;
            if (busy) bc++;
            step();
        end
        checks++; if (dn != 0 || bc != 0) begin failures++; $display("FAIL flush_quiet got=%0d/%0d exp=0/0", dn, bc); end
        checks++; if (hi !== old_hi || lo !== old_lo) begin failures++; $display("FAIL flush_hilo got=%h_%h exp=%h_%h", hi, lo, old_hi, old_lo); end
    endtask

    task automatic test_busy_ignore();
        int dn, bc;
        start = 1'b1; md_op = 4'd1; src_a = 32'd2; src_b = 32'd3;
        step();
        bc = busy ? 1 : 0; dn = 0;
        md_op = 4'd5; src_a = 32'hDEAD;
        step();
        start = 1'b0; md_op = 4'd0;
        for (int k = 0; k < 12; k++) begin
            if (busy) bc++;
            if (done) dn++;
            step();
        end
        checks++; if (bc != 5 || dn != 1) begin failures++; $display("FAIL ignore_timing got=%0d/%0d exp=5/1", bc, dn); end
        checks++; if (hi !== 32'd0 || lo !== 32'd6) begin failures++; $display("FAIL ignore_hilo got=%h_%h exp=00000000_00000006", hi, lo); end
    endtask

    task automatic test_flush_with_start();
        logic [31:0] old_hi;
        old_hi = hi;
        start = 1'b1; flush = 1'b1; md_op = 4'd5; src_a = 32'hAAAA;
        step();
        checks++; if (hi !== old_hi) begin failures++; $display("FAIL flushstart_mthi got=%h exp=%h", hi, old_hi); end
        md_op = 4'd1; src_a = 32'd9; src_b = 32'd9;
        step();
        start = 1'b0; flush = 1'b0; md_op = 4'd0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flushstart_mult_busy got=%b exp=0", busy); end
    endtask

    task automatic test_noop();
        logic [3:0] ops [$];
        logic [31:0] old_hi, old_lo;
        ops = '{4'd0, 4'd11, 4'd15};
`ifndef MD_MADD_EN
        ops.push_back(4'd7); ops.push_back(4'd8); ops.push_back(4'd9); ops.push_back(4'd10);
`endif
        foreach (ops[i]) begin
            old_hi = hi; old_lo = lo;
            start = 1'b1; md_op = ops[i]; src_a = 32'hCAFE; src_b = 32'd1;
            #1;
            checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL noop_stall op=%0d got=%b exp=0", ops[i], stall_req); end
            step();
            start = 1'b0;
            checks++; if (busy !== 1'b0 || hi !== old_hi || lo !== old_lo) begin failures++; $display("FAIL noop_state op=%0d got=%b_%h_%h exp=0_%h_%h", ops[i], busy, hi, lo, old_hi, old_lo); end
        end
        md_op = 4'd0;
    endtask

`ifdef MD_MADD_EN
    task automatic test_madd();
        int bc, dn, hb; logic st0;
        start = 1'b1; md_op = 4'd5; src_a = 32'd0; step();
        md_op = 4'd6; src_a = 32'd10; step();
        start = 1'b0;
        run_long(4'd7, 32'd3, 32'd4, bc, dn, hb, st0);
        checks++; if (bc != 5 || dn != 1 || st0 !== 1'b1) begin failures++; $display("FAIL madd_timing got=%0d/%0d/%b exp=5/1/1", bc, dn, st0); end
        checks++; if (hi !== 32'd0 || lo !== 32'd22) begin failures++; $display("FAIL madd_val got=%h_%h exp=00000000_00000016", hi, lo); end
        run_long(4'd10, 32'd1, 32'd23, bc, dn, hb, st0);
        checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL msubu_val got=%h_%h exp=ffffffff_ffffffff", hi, lo); end
    endtask
`endif

    task automatic test_reset_mid();
        int dn;
        start = 1'b1; md_op = 4'd1; src_a = 32'd5; src_b = 32'd7;
        step();
        start = 1'b0; md_op = 4'd0;
        step();
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || stall_req !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl got=%b%b%b exp=000", busy, done, stall_req); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin failures++; $display("FAIL rstmid_hilo got=%h_%h exp=00000000_00000000", hi, lo); end
        #1 rst_n = 1'b1;
        dn = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (done) dn++;
        end
        checks++; if (dn != 0 || lo !== 32'd0) begin failures++; $display("FAIL rstmid_lost got=%0d/%h exp=0/00000000", dn, lo); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; md_op = 4'd0; src_a = 32'd0; src_b = 32'd0; flush = 1'b0;
        #3;
        test_reset();
        step(); step();
        rst_n = 1'b1;
        step();
        test_reset();
        test_mthi_mtlo();
        test_mult();
        test_multu();
        test_div();
        test_flush();
        test_busy_ignore();
        test_flush_with_start();
        test_noop();
`ifdef MD_MADD_EN
        test_madd();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
